// File: rtl/imem_loader.sv
// Boot loader: takes a byte-stream program image (16-bit word count header, then
// little-endian 32-bit words) and writes it into instruction memory, holding the core in reset until done.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state  | meaning
    // IDLE   | after reset, core held in reset, waiting for start
    // HDR0   | accepting word-count low byte
    // HDR1   | accepting word-count high byte, range check
    // DATA   | accepting the four bytes of one word
    // WRITE  | one-cycle instruction-memory write strobe
    // DONE   | image complete, core released
    // ERR    | word count larger than memory, core held in reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Depth is 17 bits wide so a 16-bit count can be compared against 2**16.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t      state;
    state_t      state_next;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [15:0] hdr_n;
    logic        accept;
    logic        start_ok;

    assign accept   = in_valid & in_ready;
    assign hdr_n    = {in_data, word_cnt[7:0]};
    assign start_ok = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_HDR0;
            end
            S_HDR0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_next = S_HDR1;
            end
            S_HDR1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (hdr_n == 16'd0)
                        state_next = S_DONE;
                    else if ({1'b0, hdr_n} > DEPTH)
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_idx == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (word_cnt == 16'd1)
                    state_next = S_DONE;
                else
                    state_next = S_DATA;
            end
            S_DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start) state_next = S_HDR0;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_next = S_HDR0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: a reset mid-word drops the partially assembled word with no write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
        end else begin
            if (start_ok) begin
                imem_waddr <= '0;
                byte_idx   <= '0;
            end
            if (accept) begin
                case (state)
                    S_HDR0: word_cnt[7:0] <= in_data;
                    S_HDR1: word_cnt      <= hdr_n;
                    S_DATA: begin
                        imem_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                imem_waddr <= imem_waddr + 1'b1;
                word_cnt   <= word_cnt - 16'd1;
            end
        end
    end

endmodule
